// File: rtl/creg_fifo_if.sv
// Ready/valid bundle between the register stage, creg_fifo and its consumer.
// master drives the write side and the read-ready; slave is the FIFO itself.
interface creg_fifo_if #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]         I;
    logic                     I_valid;
    logic                     I_ready;
    logic [WIDTH-1:0]         O;
    logic                     O_valid;
    logic                     O_ready;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output I, I_valid, O_ready,
        input  I_ready, O, O_valid, count
    );

    modport slave (
        input  I, I_valid, O_ready,
        output I_ready, O, O_valid, count
    );
endinterface

// File: rtl/creg_fifo.sv
// First-word-fall-through FIFO with fill counter behind the 2-bit register stage.
// Define CREG_FIFO_BYPASS_EN for a zero-latency path through an empty FIFO.
module creg_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    creg_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head;

    assign w_full  = (r_count == FULL);
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];

`ifdef CREG_FIFO_BYPASS_EN
    logic w_bypass;
    logic w_take;

    // An empty FIFO presents the incoming word directly; if it is taken
    // in the same cycle it never touches storage.
    assign w_bypass = w_empty & bus.I_valid;
    assign w_take   = w_bypass & bus.O_ready;
    assign w_push   = bus.I_valid & ~w_full & ~w_take;
    assign w_pop    = ~w_empty & bus.O_ready;

    assign bus.O_valid = ~w_empty | w_bypass;
    assign bus.O       = ~w_empty ? w_head :
                         (w_bypass ? bus.I : '0);
`else
    assign w_push = bus.I_valid & ~w_full;
    assign w_pop  = ~w_empty & bus.O_ready;

    assign bus.O_valid = ~w_empty;
    assign bus.O       = ~w_empty ? w_head : '0;
`endif

    assign bus.I_ready = ~w_full;
    assign bus.count   = r_count;

    always_ff @(posedge CLK) begin
        if (w_push && !RESET) begin
            r_mem[r_wr_ptr] <= bus.I;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
